icache_block_fetch_ctrl: RTL and testbench
==========================================

// Module: icache_block_fetch_ctrl
// PURPOSE
//  Direct-mapped instruction cache with block-refill controller. Sits between the CPU fetch stage and
//  the 16-beat Instruction_memory. Serves 32-bit instructions on hits. On a miss it fetches a whole
//  128-bit line over the read/address/readdata/busywait protocol as the requesting side.
//  Supports a single-cycle flush (invalidate-all) used on OS-initiated cache switches.
// PARAMETERS
//  NUM_LINES  8   cache lines; power of two
//  INDEX_W    3   log2(NUM_LINES)
//  TAG_W      25  32 - INDEX_W - 4; address tag bits per line
// PORTS
//  clock           in   1    single clock; all state updates on rising edge
//  reset           in   1    synchronous, active-low; sampled on rising clock edge
//  cpu_read        in   1    fetch request; held until cpu_busywait low
//  cpu_address     in   32   byte PC; [1:0] ignored, [3:2] word, [3+INDEX_W:4] index, [31:4+INDEX_W] tag
//  flush           in   1    invalidate all lines (1-cycle pulse)
//  cpu_instruction out  32   selected word of hit line
//  cpu_busywait    out  1    1 = instruction not yet valid, CPU must stall
//  mem_read        out  1    block read request to instruction memory
//  mem_address     out  28   block address = cpu_address[31:4], registered at miss
//  mem_readdata    in   128  refill line; byte k at bits [8k+7:8k]
//  mem_busywait    in   1    memory busy; drops when final beat is being captured
// BEHAVIOUR
//  Reset (reset==0 at edge): state<=IDLE, all valid<=0, mem_read<=0, mem_address<=0.
//   cpu_busywait=0 and cpu_instruction=0 while in IDLE with cpu_read=0.
//   Reset mid-refill aborts: mem_read low from the next cycle; no line written.
//  Hit = cpu_read & valid[idx] & (tag[idx]==addr tag). Combinational:
//   cpu_busywait=0, cpu_instruction=data[idx] word [3:2]. Zero-cycle hit latency.
//  Miss = cpu_read & !hit in IDLE. cpu_busywait=1 combinationally in the same cycle.
//  FSM states:
//   IDLE     : on miss -> MEM_READ, latch mem_address=cpu_address[31:4], idx, tag.
//   MEM_READ : mem_read=1, address held stable.
//              Edge with mem_busywait==0 -> FILL, mem_read drops next cycle.
//   FILL     : mem_read=0. Write mem_readdata to data[idx] (one cycle after busywait fell,
//              so beat 15 is stable), tag[idx]<=tag, valid[idx]<=1 -> IDLE.
//              The next cycle in IDLE is a hit.
//  cpu_busywait=1 in MEM_READ and FILL regardless of cpu_read. cpu_instruction holds its last value.
//  cpu_address/cpu_read changes during a refill are ignored; the latched line completes.
//  flush in IDLE: all valid<=0 at that edge. Same-cycle request is evaluated against the pre-flush
//   contents; the next cycle sees an empty cache.
//  flush in MEM_READ/FILL: all valid<=0 at that edge. The in-flight line is still installed valid in FILL.
//  Simultaneous reset and flush: reset wins.
//  Never assert mem_read in two consecutive refills without a FILL cycle between them.
//   This guarantees the memory beat counter has wrapped back to 0.
// STRUCTURE
//  icache_params.vh: TAG_W/INDEX_W defaults, field-slice macros, state encodings
//   (IDLE=2'd0, MEM_READ=2'd1, FILL=2'd2).
//  Sub-module icache_line_store: valid/tag/data arrays with one write port (idx, tag, line, we)
//   and a flush-all input. Combinational read port.
//  Top level holds the FSM, hit compare, word mux and mem-side registers.
// TESTING
//  Use an Instruction_memory model preloaded with a known 64-byte image: 16-cycle busywait per block.
//  1 Cold miss: reset low 2 cycles, then read 0x00000004.
//    -> mem_read=1, mem_address=0; cpu_busywait high through MEM_READ+FILL (17 cycles).
//    -> Then instruction = bytes[7:4] little-endian, busywait 0.
//  2 Hit: after 1, read 0x0000000C.
//    -> busywait 0 same cycle; instruction = bytes[15:12]; mem_read stays 0.
//  3 Conflict: read 0x00000010 (idx1), then 0x00000090 (idx1, tag1).
//    -> Second access misses, mem_address=0x0000009.
//    -> Re-reading 0x10 misses again.
//  4 Flush: fill idx0, pulse flush 1 cycle, read 0x0.
//    -> Miss and full 17-cycle refill.
//    -> Flush during MEM_READ still leaves the line valid afterwards.
//  5 Reset mid-refill: assert reset 6 cycles into MEM_READ.
//    -> mem_read=0 next cycle, all lines invalid.
//    -> Subsequent read of the same address misses.
//  6 Address change during refill: switch cpu_address to 0x20 mid-MEM_READ.
//    -> mem_address stays at the original block.
//    -> After FILL the 0x20 read misses and triggers its own refill.

Source files
------------

// File: rtl/icache_block_fetch_ctrl_pkg.sv
// Shared constants for the instruction cache block-fetch controller:
// FSM encodings, line width and the word-select helper.
package icache_block_fetch_ctrl_pkg;

    localparam int LINE_W = 128;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MEM_READ = 2'd1;
    localparam logic [1:0] S_FILL     = 2'd2;

    function automatic logic [31:0] word_sel(
        input logic [LINE_W-1:0] line,
        input logic [1:0]        w
    );
        logic [31:0] r;
        case (w)
            2'd0:    r = line[31:0];
            2'd1:    r = line[63:32];
            2'd2:    r = line[95:64];
            default: r = line[127:96];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays for the direct-mapped instruction cache.
// One write port, flush-all, combinational read.
module icache_line_store
    import icache_block_fetch_ctrl_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int INDEX_W   = 3,
    parameter int TAG_W     = 25
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               we,
    input  logic [INDEX_W-1:0] widx,
    input  logic [TAG_W-1:0]   wtag,
    input  logic [LINE_W-1:0]  wline,
    input  logic [INDEX_W-1:0] ridx,
    output logic               rvalid,
    output logic [TAG_W-1:0]   rtag,
    output logic [LINE_W-1:0]  rline
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [TAG_W-1:0]     tag_d  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];
    logic [LINE_W-1:0]    data_d [NUM_LINES];

    // A refill landing on the flush edge still installs its line.
    always_comb begin
        valid_d = flush ? '0 : valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (we) begin
            valid_d[widx] = 1'b1;
            tag_d[widx]   = wtag;
            data_d[widx]  = wline;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rvalid = valid_q[ridx];
    assign rtag   = tag_q[ridx];
    assign rline  = data_q[ridx];

endmodule

// File: rtl/icache_block_fetch_ctrl.sv
// Direct-mapped I-cache front end: hit compare, word mux and the
// IDLE/MEM_READ/FILL block-refill FSM towards instruction memory.
module icache_block_fetch_ctrl
    import icache_block_fetch_ctrl_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int INDEX_W   = 3,
    parameter int TAG_W     = 32 - INDEX_W - 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cpu_read,
    input  logic [31:0]        cpu_address,
    input  logic               flush,
    output logic [31:0]        cpu_instruction,
    output logic               cpu_busywait,
    output logic               mem_read,
    output logic [27:0]        mem_address,
    input  logic [LINE_W-1:0]  mem_readdata,
    input  logic               mem_busywait
);

    logic [1:0]         state_q, state_d;
    logic               mem_read_q, mem_read_d;
    logic [27:0]        mem_address_q, mem_address_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic [TAG_W-1:0]   ltag_q, ltag_d;
    logic [31:0]        instr_q, instr_d;

    logic [INDEX_W-1:0] a_idx;
    logic [TAG_W-1:0]   a_tag;
    logic               l_valid;
    logic [TAG_W-1:0]   l_tag;
    logic [LINE_W-1:0]  l_line;
    logic               hit;
    logic               unused_byte_bits;

    assign a_idx            = cpu_address[3+INDEX_W:4];
    assign a_tag            = cpu_address[31:4+INDEX_W];
    assign unused_byte_bits = ^cpu_address[1:0];

    icache_line_store #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W)
    ) u_store (
        .clock  (clock),
        .reset  (reset),
        .flush  (flush),
        .we     (state_q == S_FILL),
        .widx   (idx_q),
        .wtag   (ltag_q),
        .wline  (mem_readdata),
        .ridx   (a_idx),
        .rvalid (l_valid),
        .rtag   (l_tag),
        .rline  (l_line)
    );

    assign hit = cpu_read & l_valid & (l_tag == a_tag);

    always_comb begin
        state_d         = state_q;
        mem_address_d   = mem_address_q;
        idx_d           = idx_q;
        ltag_d          = ltag_q;
        cpu_busywait    = 1'b1;
        cpu_instruction = instr_q;
        case (state_q)
            S_IDLE: begin
                if (!cpu_read) begin
                    cpu_busywait    = 1'b0;
                    cpu_instruction = '0;
                end else if (hit) begin
                    cpu_busywait    = 1'b0;
                    cpu_instruction = word_sel(l_line, cpu_address[3:2]);
                end else begin
                    state_d       = S_MEM_READ;
                    mem_address_d = cpu_address[31:4];
                    idx_d         = a_idx;
                    ltag_d        = a_tag;
                end
            end
            S_MEM_READ: begin
                if (!mem_busywait) state_d = S_FILL;
            end
            S_FILL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // FILL always separates two MEM_READ phases, so the memory
        // beat counter is back at zero before the next request.
        mem_read_d = (state_d == S_MEM_READ);
        instr_d    = cpu_instruction;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            idx_q         <= '0;
            ltag_q        <= '0;
            instr_q       <= '0;
        end else begin
            state_q       <= state_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            idx_q         <= idx_d;
            ltag_q        <= ltag_d;
            instr_q       <= instr_d;
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_address = mem_address_q;

endmodule

// File: tb/tb_icache_block_fetch_ctrl.sv
// Bench for icache_block_fetch_ctrl: 64-byte instruction memory model
// with a 16-beat busywait, scoreboard of expected fetch words.
module tb_icache_block_fetch_ctrl;

    logic         clock = 1'b0;
    logic         reset;
    logic         cpu_read;
    logic [31:0]  cpu_address;
    logic         flush;
    logic [31:0]  cpu_instruction;
    logic         cpu_busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    logic [7:0]   img [64];
    logic [3:0]   beat;
    logic [31:0]  exp_q [$];
    int           checks   = 0;
    int           failures = 0;

    always #5 clock = ~clock;

    icache_block_fetch_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .cpu_read        (cpu_read),
        .cpu_address     (cpu_address),
        .flush           (flush),
        .cpu_instruction (cpu_instruction),
        .cpu_busywait    (cpu_busywait),
        .mem_read        (mem_read),
        .mem_address     (mem_address),
        .mem_readdata    (mem_readdata),
        .mem_busywait    (mem_busywait)
    );

    // Memory: busy for beats 0..14, drops on beat 15, wraps to 0.
    always @(posedge clock) begin
        beat <= mem_read ? beat + 4'd1 : 4'd0;
    end

    assign mem_busywait = mem_read && (beat != 4'd15);

    always_comb begin
        mem_readdata = '0;
        for (int k = 0; k < 16; k++) begin
            mem_readdata[8*k +: 8] = img[{mem_address[1:0], 4'(k)}];
        end
    end

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [5:0] b;
        b = {a[5:2], 2'b00};
        return {img[b + 6'd3], img[b + 6'd2], img[b + 6'd1], img[b]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One fetch; optional address switch / flush pulse after the
    // given number of mem_read cycles. Stall count includes the
    // miss-detect cycle in IDLE.
    task automatic fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] addr2, input int sw_at,
                         input int fl_at, input int exp_mr,
                         input int exp_stall, input logic [27:0] exp_ma,
                         input logic [27:0] exp_ma2);
        int          mr = 0;
        int          st = 0;
        int          busy_mr = 0;
        bit          seen = 0;
        bit          ended = 0;
        bit          done = 0;
        logic [27:0] ma_first = '0;
        logic [27:0] ma_end = '0;
        logic [27:0] ma_last = '0;
        logic [31:0] e;
        exp_q.push_back(exp_word(sw_at >= 0 ? addr2 : addr));
        cpu_read    = 1'b1;
        cpu_address = addr;
        for (int i = 0; i < 200 && !done; i++) begin
            #4;
            if (!cpu_busywait) begin
                e = exp_q.pop_front();
                chk({tag, "_instr"}, 64'(cpu_instruction), 64'(e));
                done = 1;
            end else begin
                st++;
                if (mem_read) begin
                    if (!seen) ma_first = mem_address;
                    seen = 1;
                    mr++;
                    if (!mem_busywait && !ended) begin
                        ma_end = mem_address;
                        ended  = 1;
                    end
                    ma_last = mem_address;
                end
                if (seen) busy_mr++;
                @(posedge clock);
                #1;
                if (sw_at >= 0 && mr >= sw_at) cpu_address = addr2;
                flush = (mr == fl_at);
            end
        end
        if (!done) begin
            chk({tag, "_timeout"}, 64'(1), 64'(0));
            void'(exp_q.pop_front());
        end
        chk({tag, "_mr_cycles"}, 64'(mr), 64'(exp_mr));
        chk({tag, "_stall"}, 64'(st), 64'(exp_stall));
        if (exp_mr > 0) begin
            chk({tag, "_busy_from_mr"}, 64'(busy_mr), 64'(exp_stall - 1));
            chk({tag, "_ma_first"}, 64'(ma_first), 64'(exp_ma));
            chk({tag, "_ma_end"}, 64'(ma_end), 64'(exp_ma));
            chk({tag, "_ma_last"}, 64'(ma_last), 64'(exp_ma2));
        end
        @(posedge clock);
        #1;
        cpu_read = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        int mr;
        for (int i = 0; i < 64; i++) img[i] = 8'(i * 37 + 11);
        reset       = 1'b0;
        cpu_read    = 1'b0;
        cpu_address = '0;
        flush       = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", 64'(cpu_busywait), 64'(0));
        chk("rst_instr", 64'(cpu_instruction), 64'(0));
        chk("rst_mem_read", 64'(mem_read), 64'(0));
        chk("rst_mem_addr", 64'(mem_address), 64'(0));
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Miss: detect cycle + 16 MEM_READ + 1 FILL.
        fetch("cold", 32'h04, 32'h0, -1, -1, 16, 18, 28'h0, 28'h0);
        fetch("hit", 32'h0C, 32'h0, -1, -1, 0, 0, 28'h0, 28'h0);
        fetch("c10", 32'h10, 32'h0, -1, -1, 16, 18, 28'h1, 28'h1);
        fetch("c90", 32'h90, 32'h0, -1, -1, 16, 18, 28'h9, 28'h9);
        fetch("c10b", 32'h10, 32'h0, -1, -1, 16, 18, 28'h1, 28'h1);

        // Same-cycle request sees pre-flush contents.
        cpu_read    = 1'b1;
        cpu_address = 32'h0;
        flush       = 1'b1;
        #4;
        chk("fl_same_busy", 64'(cpu_busywait), 64'(0));
        chk("fl_same_instr", 64'(cpu_instruction), 64'(exp_word(32'h0)));
        @(posedge clock);
        #1;
        flush    = 1'b0;
        cpu_read = 1'b0;
        #1;
        chk("idle_instr", 64'(cpu_instruction), 64'(0));
        @(posedge clock);
        #1;
        fetch("fl_idle", 32'h00, 32'h0, -1, -1, 16, 18, 28'h0, 28'h0);
        fetch("fl_mr", 32'h30, 32'h0, -1, 5, 16, 18, 28'h3, 28'h3);
        fetch("fl_mr_hit", 32'h34, 32'h0, -1, -1, 0, 0, 28'h0, 28'h0);
        fetch("fl_mr_gone", 32'h08, 32'h0, -1, -1, 16, 18, 28'h0, 28'h0);

        // Reset six cycles into MEM_READ.
        cpu_read    = 1'b1;
        cpu_address = 32'h40;
        mr          = 0;
        for (int i = 0; i < 40 && mr < 6; i++) begin
            #4;
            if (mem_read) mr++;
            @(posedge clock);
            #1;
        end
        chk("mid_mr_seen", 64'(mr), 64'(6));
        reset = 1'b0;
        @(posedge clock);
        #1;
        cpu_read = 1'b0;
        #3;
        chk("mid_rst_mem_read", 64'(mem_read), 64'(0));
        chk("mid_rst_mem_addr", 64'(mem_address), 64'(0));
        chk("mid_rst_busy", 64'(cpu_busywait), 64'(0));
        reset = 1'b1;
        @(posedge clock);
        #1;
        fetch("post_rst_0", 32'h04, 32'h0, -1, -1, 16, 18, 28'h0, 28'h0);
        fetch("post_rst_40", 32'h40, 32'h0, -1, -1, 16, 18, 28'h4, 28'h4);

        // Address switch mid-refill: two back-to-back refills.
        fetch("sw", 32'h60, 32'h20, 4, -1, 32, 36, 28'h6, 28'h2);
        fetch("sw_hit60", 32'h68, 32'h0, -1, -1, 0, 0, 28'h0, 28'h0);
        fetch("sw_hit20", 32'h24, 32'h0, -1, -1, 0, 0, 28'h0, 28'h0);

        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
